// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Saturates to all nines with an overflow flag when the value exceeds the digit count.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  overflow
);

    localparam int INT_DIGITS = (WIDTH + 2) / 3;
    localparam int MAX_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
    localparam int CW         = $clog2(WIDTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready and out_valid depend on state only; valid, once raised, holds until the transfer.
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [WIDTH-1:0]          r_shreg;
    logic [4*INT_DIGITS-1:0]   r_scratch;
    logic [CW-1:0]             r_cnt;
    logic [4*DIGITS-1:0]       r_bcd;
    logic [DIGITS-1:0]         r_den;
    logic                      r_ovf;

    logic                      w_last;
    logic [4*INT_DIGITS-1:0]   w_adj;
    logic [4*INT_DIGITS-1:0]   w_scratch_nx;
    logic [4*MAX_DIGITS-1:0]   w_ext;
    logic                      w_ovf;
    logic [4*DIGITS-1:0]       w_bcd;
    logic [DIGITS-1:0]         w_den;
    logic                      w_any;

    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CONV;
            S_CONV:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Add-3 correction precedes the shift so every digit stays within 0..9.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    assign w_scratch_nx = {w_adj[4*INT_DIGITS-2:0], r_shreg[WIDTH-1]};

    always_comb begin
        w_ext = '0;
        w_ext[4*INT_DIGITS-1:0] = w_scratch_nx;
        w_ovf = 1'b0;
        for (int k = DIGITS; k < MAX_DIGITS; k++) begin
            if (w_ext[4*k +: 4] != 4'd0) w_ovf = 1'b1;
        end
    end

    assign w_bcd = w_ovf ? {DIGITS{4'h9}} : w_ext[4*DIGITS-1:0];

    // A digit is lit when it or any more significant digit is nonzero; units always lit.
    always_comb begin
        w_any = 1'b0;
        w_den = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_any    = w_any | (w_bcd[4*k +: 4] != 4'd0);
            w_den[k] = w_any;
        end
        w_den[0] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_den     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shreg   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= CW'(WIDTH);
                    end
                end
                S_CONV: begin
                    r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_scratch <= w_scratch_nx;
                    r_cnt     <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_bcd <= w_bcd;
                        r_den <= w_den;
                        r_ovf <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign bcd       = r_bcd;
    assign digit_en  = r_den;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, random values against a decimal model,
// plus backpressure and mid-conversion reset sequences.
module tb_bin_to_bcd_seq;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic [2:0]  digit_en;
    logic        overflow;

    int n_pass;
    int n_total;

    // Expected result packed as {overflow, digit_en, bcd}.
    logic [15:0] exp_q[$];

    typedef struct {
        logic [11:0] bin;
        logic [11:0] bcd;
        logic [2:0]  den;
        logic        ovf;
    } vec_t;

    vec_t tbl[9];

    bin_to_bcd_seq #(.WIDTH(12), .DIGITS(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .digit_en  (digit_en),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] model(input int v);
        int d0, d1, d2;
        logic [2:0] den;
        if (v > 999) return {1'b1, 3'b111, 12'h999};
        d0 = v % 10;
        d1 = (v / 10) % 10;
        d2 = v / 100;
        den[0] = 1'b1;
        den[1] = (d1 != 0) || (d2 != 0);
        den[2] = (d2 != 0);
        return {1'b0, den, d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    task automatic compare_result(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: output seen with empty expected queue", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {16'd0, overflow, digit_en, bcd}, {16'd0, e});
        end
    endtask

    // Accepts one value, checks latency and the popped result, then the return to idle.
    task automatic convert(input logic [11:0] v, input logic [15:0] e);
        int lat;
        bit got;
        out_ready = 1'b1;
        @(negedge clock);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        bin      = v;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        bin      = 12'($urandom_range(0, 4095));
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
            if (out_valid) got = 1'b1;
        end
        check("latency", lat, 12);
        if (got) begin
            compare_result("result");
            @(posedge clock);
            #1;
            check("out_valid_drop", {31'd0, out_valid}, 32'd0);
            check("in_ready_back", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [15:0] e;
        int   waited;
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = '0;

        tbl[0] = '{12'd0,    12'h000, 3'b001, 1'b0};
        tbl[1] = '{12'd255,  12'h255, 3'b111, 1'b0};
        tbl[2] = '{12'd7,    12'h007, 3'b001, 1'b0};
        tbl[3] = '{12'd40,   12'h040, 3'b011, 1'b0};
        tbl[4] = '{12'd999,  12'h999, 3'b111, 1'b0};
        tbl[5] = '{12'd1000, 12'h999, 3'b111, 1'b1};
        tbl[6] = '{12'd4095, 12'h999, 3'b111, 1'b1};
        tbl[7] = '{12'd100,  12'h100, 3'b111, 1'b0};
        tbl[8] = '{12'd10,   12'h010, 3'b011, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bcd", {20'd0, bcd}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_digit_en", {29'd0, digit_en}, 32'd0);

        for (int i = 0; i < 9; i++)
            convert(tbl[i].bin, {tbl[i].ovf, tbl[i].den, tbl[i].bcd});

        for (int i = 0; i < 6; i++) begin
            logic [11:0] r;
            r = 12'($urandom_range(0, 4095));
            convert(r, model(int'(r)));
        end

        // Backpressure: result held while out_ready is low and in_valid keeps toggling bin.
        out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        bin      = 12'd200;
        e        = model(200);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 40) begin
            @(posedge clock);
            waited++;
            #1;
        end
        check("bp_reached_done", {31'd0, out_valid}, 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {16'd0, overflow, digit_en, bcd}, {16'd0, e});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clock);
            in_valid = 1'b1;
            bin      = 12'($urandom_range(0, 4095));
            @(posedge clock);
            #1;
        end
        check("bp_hold_end", {16'd0, overflow, digit_en, bcd}, {16'd0, e});
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_bcd_kept", {20'd0, bcd}, {20'd0, e[11:0]});

        // Reset six cycles into a conversion; the next conversion must be clean.
        @(negedge clock);
        in_valid = 1'b1;
        bin      = 12'd123;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_bcd", {20'd0, bcd}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_no_output", {31'd0, out_valid}, 32'd0);
        convert(12'd42, {1'b0, 3'b011, 12'h042});

        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock.
- Sits upstream of the seven-segment display path: takes a binary result from the core (e.g. a Fibonacci value) and produces true decimal digits.
- Each output digit is a 4-bit BCD nibble that the per-digit segment decoders consume directly.
- Valid/ready handshakes on both sides; values too large for the display saturate to all nines and raise an overflow flag.

Parameters:
- WIDTH, 12, bit width of the binary input (≥ 4).
- DIGITS, 3, number of BCD digits presented at the output (≥ 1).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  bin carries a value to convert.
- in_ready  output  1  converter idle and able to accept; combinational from state only.
- bin  input  WIDTH  unsigned binary value.
- out_valid  output  1  bcd/overflow/digit_en hold a finished result.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  BCD result, digit 0 (units) in bits [3:0], digit k in [4k+3:4k].
- digit_en  output  DIGITS  leading-zero blanking mask; bit k = 1 if digit k is to be lit.
- overflow  output  1  input exceeded 10^DIGITS − 1; bcd saturated.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; any in-flight conversion is discarded.
  - out_valid=0, bcd=0, digit_en=0, overflow=0. in_ready=1 in the first cycle after reset deasserts.
- Internal storage:
  - Binary shift register of WIDTH bits.
  - BCD scratch of INT_DIGITS=(WIDTH+2)/3 digits. This is always enough, since 2^(3k) < 10^k.
  - Bit counter of clog2(WIDTH+1) bits.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load bin into the shift register, clear the scratch, set counter=WIDTH, go to CONV.
- State CONV:
  - in_ready=0.
  - Each edge, in one step: every scratch digit ≥5 gets +3, then {scratch, shreg} shifts left by 1 (MSB of bin enters digit 0 LSB), and counter decrements.
  - When counter reaches 0 on this edge (the WIDTH-th shift), go to DONE on the same edge and register the outputs:
    - overflow = OR of scratch digits DIGITS..INT_DIGITS−1 being nonzero (0 if INT_DIGITS ≤ DIGITS).
    - bcd = all 4'h9 if overflow, else the low DIGITS scratch digits.
    - digit_en[0]=1. digit_en[k]=1 if any digit j≥k of the output bcd is nonzero. When overflow=1, all bits are 1.
    - out_valid=1.
- State DONE:
  - out_valid=1; all outputs are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. bcd, digit_en and overflow keep their values until the next result.
- Latency: out_valid rises on the WIDTH-th edge after the accept edge.
- Throughput: in_ready is 0 from the accept edge until the edge after the output handshake, so the minimum spacing between accepts is WIDTH+2 cycles.
- Input port in non-IDLE states: in_valid is ignored and bin is never sampled.
- Simultaneous events:
  - reset has priority over every handshake.
  - out_ready is ignored outside DONE.
  - There is no accept in the same cycle as the output handshake.
- Arithmetic: bin is unsigned; +3 is applied only to digits ≥5, so no digit ever exceeds 9 after a shift.
- Reset mid-CONV or mid-DONE: the result is lost and out_valid drops on the reset edge.

Test Plan:
- After reset, check the idle state: in_ready=1, out_valid=0, bcd=0x000, overflow=0.
- Zero input: bin=0, out_ready=1 → out_valid on the 12th edge after accept, bcd=0x000, digit_en=3'b001, overflow=0.
- Mid-range input: bin=255 → bcd=0x255, digit_en=3'b111.
- Blanking: bin=7 → bcd=0x007, digit_en=3'b001. bin=40 → bcd=0x040, digit_en=3'b011.
- Saturation boundary:
  - bin=999 → bcd=0x999, overflow=0.
  - bin=1000 → bcd=0x999, overflow=1, digit_en=3'b111.
  - bin=4095 → same as 1000.
- Backpressure: result ready with out_ready=0 held for 5 cycles, in_valid=1 with changing bin → outputs stable, in_ready=0, no new accept. Raising out_ready → out_valid=0, and in_ready=1 next cycle.
- Reset mid-conversion: assert reset 6 cycles after accepting bin=123 → out_valid=0, in_ready=1 after reset. A new bin=42 then produces bcd=0x042 with no residue.
